// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch path: queue entry layout and IF stage register.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_next;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // The IF stage register carries exactly what a queue entry holds.
    typedef fetch_entry_t if_stage_reg_t;

    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: redirect input, instruction memory port and decode handshake.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            i_redirect;
    logic [XLEN-1:0] i_redirect_pc;
    logic [XLEN-1:0] imem_addr;
    logic [3:0]      imem_rmask;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_resp;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_inst;
    logic [XLEN-1:0] o_pc;
    logic [XLEN-1:0] o_pc_next;

    modport master (
        input  i_redirect, i_redirect_pc, imem_rdata, imem_resp, i_ready,
        output imem_addr, imem_rmask, o_valid, o_inst, o_pc, o_pc_next
    );

    modport slave (
        output i_redirect, i_redirect_pc, imem_rdata, imem_resp, i_ready,
        input  imem_addr, imem_rmask, o_valid, o_inst, o_pc, o_pc_next
    );

endinterface

// File: rtl/fetch_unit_queue.sv
// DEPTH-entry FIFO of fetch entries with flush; head is read straight from registered storage.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  fetch_entry_t                 push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output fetch_entry_t                 head_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_c, do_pop_c;

    // Pointer and occupancy update; flush wins over push/pop.
    always_comb begin
        do_push_c = push_i && !flush_i;
        do_pop_c  = pop_i && (count_q != '0) && !flush_i;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush_i) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (do_push_c) tail_d = tail_q + PW'(1);
            if (do_pop_c)  head_d = head_q + PW'(1);
            count_d = count_q + CW'(do_push_c) - CW'(do_pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[tail_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[head_q];

endmodule

// File: rtl/fetch_unit.sv
// Request-pipelined instruction fetcher: issues up to DEPTH credits, queues responses, drops stale ones after redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h6000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count_w;
    logic [SW-1:0]   credit_c;
    logic            issue_c;
    logic            enq_c;
    logic            pop_c;
    fetch_entry_t    enq_entry_c;
    fetch_entry_t    head_w;

    // Issue/credit logic and the PC / drop bookkeeping; redirect overrides everything except rst.
    always_comb begin
        credit_c    = SW'(count_w) + SW'(inflight_q);
        issue_c     = !rst && !bus.i_redirect && (credit_c < SW'(DEPTH));
        enq_c       = bus.imem_resp && (drop_q == '0) && !bus.i_redirect;
        pop_c       = bus.i_ready && (count_w != '0);
        inflight_d  = inflight_q + CW'(issue_c) - CW'(bus.imem_resp);
        enq_entry_c = '{pc: resp_pc_q, pc_next: pc_inc(resp_pc_q), inst: bus.imem_rdata};
        pc_d        = pc_q;
        resp_pc_d   = resp_pc_q;
        drop_d      = drop_q;
        if (bus.i_redirect) begin
            pc_d      = bus.i_redirect_pc;
            resp_pc_d = bus.i_redirect_pc;
            drop_d    = inflight_d;
        end else begin
            if (issue_c) pc_d = pc_inc(pc_q);
            if (enq_c)   resp_pc_d = pc_inc(resp_pc_q);
            if (bus.imem_resp && (drop_q != '0)) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (enq_c),
        .push_data_i (enq_entry_c),
        .pop_i       (pop_c),
        .flush_i     (bus.i_redirect),
        .count_o     (count_w),
        .head_o      (head_w)
    );

    assign bus.imem_addr  = pc_q;
    assign bus.imem_rmask = issue_c ? 4'hF : 4'h0;
    assign bus.o_valid    = (count_w != '0);
    assign bus.o_inst     = head_w.inst;
    assign bus.o_pc       = head_w.pc;
    assign bus.o_pc_next  = head_w.pc_next;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order variable-latency instruction memory model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h6000_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    logic clk;
    logic rst;
    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          rand_lat = 0;
    int          n_issue = 0;
    int          n_hs = 0;
    logic [31:0] first_issue_addr;
    logic [31:0] exp_pc;
    req_t        mq[$];
    logic        obs_valid;
    logic [3:0]  obs_rmask;
    logic [31:0] obs_addr;
    bit          obs_hs;
    logic [31:0] obs_hs_pc;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5C3_0F69;
    endfunction

    // One clock cycle: memory answers, outputs sampled mid-cycle, then the edge.
    task automatic step();
        req_t r;
        int   l;
        bus.imem_resp  = 1'b0;
        bus.imem_rdata = '0;
        if (!rst && mq.size() != 0 && mq[0].due <= cyc) begin
            r = mq.pop_front();
            bus.imem_resp  = 1'b1;
            bus.imem_rdata = inst_of(r.addr);
        end
        #1;
        obs_valid = bus.o_valid;
        obs_rmask = bus.imem_rmask;
        obs_addr  = bus.imem_addr;
        obs_hs    = 1'b0;
        if (bus.imem_rmask == 4'hF) begin
            l = rand_lat ? int'($urandom_range(5, 1)) : lat;
            mq.push_back('{addr: bus.imem_addr, due: cyc + l});
            if (n_issue == 0) first_issue_addr = bus.imem_addr;
            n_issue++;
        end
        if (!rst && bus.o_valid === 1'b1 && bus.i_ready) begin
            obs_hs    = 1'b1;
            obs_hs_pc = bus.o_pc;
            n_hs++;
            tests++;
            if (bus.o_pc !== exp_pc || bus.o_inst !== inst_of(exp_pc) || bus.o_pc_next !== exp_pc + 32'd4) begin
                fails++;
                $display("FAIL handshake cyc=%0d got pc=%h inst=%h pc_next=%h required pc=%h inst=%h pc_next=%h",
                         cyc, bus.o_pc, bus.o_inst, bus.o_pc_next, exp_pc, inst_of(exp_pc), exp_pc + 32'd4);
            end
            exp_pc = exp_pc + 32'd4;
        end
        if (!rst && bus.i_redirect) exp_pc = bus.i_redirect_pc;
        if (!rst) begin
            tests++;
            if (int'(dut.count_w) + int'(dut.inflight_q) > 4) begin
                fails++;
                $display("FAIL credit cyc=%0d got count+inflight=%0d required <= 4",
                         cyc, int'(dut.count_w) + int'(dut.inflight_q));
            end
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
            exp_pc = RST_PC;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.i_redirect   = 1'b0;
        bus.i_redirect_pc = '0;
        bus.i_ready      = 1'b0;
        rand_lat         = 0;
        step();
        step();
        rst     = 1'b0;
        cyc     = 0;
        n_issue = 0;
        n_hs    = 0;
    endtask

    // Steps until a handshake or budget expiry; returns cycles spent before the handshake.
    task automatic wait_hs(input int budget, output int idx, output bit found);
        found = 0;
        idx   = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (obs_hs) begin
                found = 1;
                idx   = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_redirect = 1'b0;
        bus.i_redirect_pc = '0;
        bus.i_ready = 1'b1;
        step();
        step();
        tests++; if (obs_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b required 0", obs_valid); end
        tests++; if (obs_rmask !== 4'h0) begin fails++; $display("FAIL reset_rmask got %h required 0", obs_rmask); end
        tests++; if (obs_addr !== RST_PC) begin fails++; $display("FAIL reset_addr got %h required %h", obs_addr, RST_PC); end
        rst = 1'b0;
        cyc = 0;
        n_issue = 0;
        step();
        tests++; if (obs_rmask !== 4'hF || obs_addr !== RST_PC) begin
            fails++; $display("FAIL first_issue got rmask=%h addr=%h required F %h", obs_rmask, obs_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        do_reset();
        lat = 1;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            tests++;
            if (obs_rmask !== 4'hF || obs_addr !== RST_PC + 32'(4 * i)) begin
                fails++; $display("FAIL stream_issue%0d got rmask=%h addr=%h required F %h", i, obs_rmask, obs_addr, RST_PC + 32'(4 * i));
            end
            tests++;
            if (i < 2) begin
                if (obs_valid !== 1'b0) begin fails++; $display("FAIL stream_early_valid%0d got %b required 0", i, obs_valid); end
            end else if (!obs_hs || obs_hs_pc !== RST_PC + 32'(4 * (i - 2))) begin
                fails++; $display("FAIL stream_deq%0d got hs=%b pc=%h required 1 %h", i, obs_hs, obs_hs_pc, RST_PC + 32'(4 * (i - 2)));
            end
        end
    endtask

    task automatic test_stall();
        int hs;
        do_reset();
        lat = 1;
        bus.i_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        tests++; if (n_issue != 4) begin fails++; $display("FAIL stall_issues got %0d required 4", n_issue); end
        tests++; if (obs_rmask !== 4'h0 || obs_valid !== 1'b1) begin
            fails++; $display("FAIL stall_full got rmask=%h valid=%b required 0 1", obs_rmask, obs_valid);
        end
        bus.i_ready = 1'b1;
        n_issue = 0;
        hs = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (obs_hs) hs++;
        end
        tests++; if (hs != 4) begin fails++; $display("FAIL stall_drain got %0d required 4", hs); end
        tests++; if (n_issue == 0 || first_issue_addr !== RST_PC + 32'h10) begin
            fails++; $display("FAIL stall_resume got issues=%0d addr=%h required >0 %h", n_issue, first_issue_addr, RST_PC + 32'h10);
        end
    endtask

    task automatic test_redirect_inflight();
        int idx;
        bit found;
        do_reset();
        lat = 3;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        tests++; if (n_issue != 3) begin fails++; $display("FAIL rdi_inflight got %0d required 3", n_issue); end
        bus.i_redirect = 1'b1;
        bus.i_redirect_pc = 32'h6000_0100;
        step();
        tests++; if (obs_rmask !== 4'h0) begin fails++; $display("FAIL rdi_no_issue got %h required 0", obs_rmask); end
        bus.i_redirect = 1'b0;
        step();
        tests++; if (obs_valid !== 1'b0 || obs_rmask !== 4'hF || obs_addr !== 32'h6000_0100) begin
            fails++; $display("FAIL rdi_restart got valid=%b rmask=%h addr=%h required 0 F 60000100", obs_valid, obs_rmask, obs_addr);
        end
        wait_hs(20, idx, found);
        tests++; if (!found || idx != 3 || obs_hs_pc !== 32'h6000_0100) begin
            fails++; $display("FAIL rdi_first got found=%b idx=%0d pc=%h required 1 3 60000100", found, idx, obs_hs_pc);
        end
    endtask

    task automatic test_redirect_resp_deq();
        int idx;
        bit found;
        do_reset();
        lat = 2;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        bus.i_redirect = 1'b1;
        bus.i_redirect_pc = 32'h6000_0180;
        step();
        tests++; if (!obs_hs || obs_hs_pc !== 32'h6000_000C || obs_rmask !== 4'h0) begin
            fails++; $display("FAIL rrd_kept got hs=%b pc=%h rmask=%h required 1 6000000c 0", obs_hs, obs_hs_pc, obs_rmask);
        end
        tests++; if (dut.drop_q !== 1) begin fails++; $display("FAIL rrd_drop got %0d required 1", dut.drop_q); end
        bus.i_redirect = 1'b0;
        wait_hs(20, idx, found);
        tests++; if (!found || idx != 3 || obs_hs_pc !== 32'h6000_0180) begin
            fails++; $display("FAIL rrd_first got found=%b idx=%0d pc=%h required 1 3 60000180", found, idx, obs_hs_pc);
        end
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_back_to_back();
        int idx;
        bit found;
        do_reset();
        lat = 2;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        bus.i_redirect = 1'b1;
        bus.i_redirect_pc = 32'h6000_0200;
        step();
        bus.i_redirect_pc = 32'h6000_0300;
        step();
        tests++; if (obs_rmask !== 4'h0 || obs_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_second got rmask=%h valid=%b required 0 0", obs_rmask, obs_valid);
        end
        bus.i_redirect = 1'b0;
        step();
        tests++; if (obs_valid !== 1'b0 || obs_rmask !== 4'hF || obs_addr !== 32'h6000_0300) begin
            fails++; $display("FAIL b2b_restart got valid=%b rmask=%h addr=%h required 0 F 60000300", obs_valid, obs_rmask, obs_addr);
        end
        wait_hs(20, idx, found);
        tests++; if (!found || obs_hs_pc !== 32'h6000_0300) begin
            fails++; $display("FAIL b2b_first got found=%b pc=%h required 1 60000300", found, obs_hs_pc);
        end
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_random();
        do_reset();
        rand_lat = 1;
        for (int i = 0; i < 10000; i++) begin
            bus.i_ready       = ($urandom_range(3, 0) != 0);
            bus.i_redirect    = ($urandom_range(49, 0) == 0);
            bus.i_redirect_pc = 32'h6000_0000 | (32'($urandom_range(16'hFFFF, 0)) << 2);
            step();
        end
        bus.i_redirect = 1'b0;
        tests++; if (n_hs < 1000) begin fails++; $display("FAIL random_progress got %0d handshakes required >= 1000", n_hs); end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_redirect = 1'b0;
        bus.i_redirect_pc = '0;
        bus.i_ready = 1'b0;
        bus.imem_resp = 1'b0;
        bus.imem_rdata = '0;
        exp_pc = RST_PC;
        first_issue_addr = '0;
        obs_hs_pc = '0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_resp_deq();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
